// File: rtl/updown_cmd_gen_pkg.sv
// Shared types and default timing constants for the up/down command generator.
package updown_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD_UP = 3'd1,
        ST_RPT_UP  = 3'd2,
        ST_HOLD_DN = 3'd3,
        ST_RPT_DN  = 3'd4,
        ST_LOCK    = 3'd5
    } cmd_state_e;

    localparam int DEB_CYC_D = 4;
    localparam int RPT_DLY_D = 8;
    localparam int RPT_PER_D = 4;

endpackage

// File: rtl/updown_cmd_gen_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output level only
// follows the synchronized input after it has differed for DEB_CYC cycles.
module debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter stays below DEB_CYC: it clears on the flip, so it never wraps.
    always_comb begin
        s1_d    = btn_i;
        s2_d    = s1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CW'(DEB_CYC - 1)) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/updown_cmd_gen.sv
// Turns two debounced push-buttons into single-cycle up/down pulses with
// auto-repeat, conflict lockout and full-flag suppression of up pulses.
module updown_cmd_gen
    import updown_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_D,
    parameter int RPT_DLY = RPT_DLY_D,
    parameter int RPT_PER = RPT_PER_D
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_up_i,
    input  logic btn_dn_i,
    input  logic full_i,
    output logic up_o,
    output logic down_o,
    output logic drop_o
);

    localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic          deb_up, deb_dn;
    cmd_state_e    state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] lim;
    logic          pulse_up, pulse_dn;
    logic          up_q, up_d, down_q, down_d, drop_q, drop_d;

    debounce #(.DEB_CYC(DEB_CYC)) u_deb_up (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_up_i),
        .level_o (deb_up)
    );

    debounce #(.DEB_CYC(DEB_CYC)) u_deb_dn (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_dn_i),
        .level_o (deb_dn)
    );

    // One repeat counter is shared: only one direction can be active at a time.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pulse_up = 1'b0;
        pulse_dn = 1'b0;
        lim      = (state_q == ST_HOLD_UP || state_q == ST_HOLD_DN) ?
                   RW'(RPT_DLY - 1) : RW'(RPT_PER - 1);
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (deb_up && deb_dn) begin
                    state_d = ST_LOCK;
                end else if (deb_up) begin
                    state_d  = ST_HOLD_UP;
                    pulse_up = 1'b1;
                end else if (deb_dn) begin
                    state_d  = ST_HOLD_DN;
                    pulse_dn = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD_UP, ST_RPT_UP: begin
                if (deb_dn) begin
                    state_d = ST_LOCK;
                    cnt_d   = '0;
                end else if (!deb_up) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= lim) begin
                    state_d  = ST_RPT_UP;
                    cnt_d    = '0;
                    pulse_up = 1'b1;
                end else begin
                    cnt_d = cnt_q + RW'(1);
                end
            end
            ST_HOLD_DN, ST_RPT_DN: begin
                if (deb_up) begin
                    state_d = ST_LOCK;
                    cnt_d   = '0;
                end else if (!deb_dn) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= lim) begin
                    state_d  = ST_RPT_DN;
                    cnt_d    = '0;
                    pulse_dn = 1'b1;
                end else begin
                    cnt_d = cnt_q + RW'(1);
                end
            end
            ST_LOCK: begin
                cnt_d = '0;
                if (!deb_up && !deb_dn) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        up_d   = pulse_up & ~full_i;
        drop_d = pulse_up & full_i;
        down_d = pulse_dn;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            up_q    <= up_d;
            down_q  <= down_d;
            drop_q  <= drop_d;
        end
    end

    assign up_o   = up_q;
    assign down_o = down_q;
    assign drop_o = drop_q;

endmodule
